haar_lift_stage: RTL and testbench

- Single-level integer Haar lifting stage for the wavelet datapath; sits directly upstream of the coefficient register bank.
- Consumes a stream of signed samples, pairs them even/odd, and emits one approximation (s) and one detail (d) coefficient per pair.
- Reversible integer lifting; the approximation/detail pairs load the downstream register bank.
- Valid/ready handshake on both sides; frames are delimited by a last flag.

---
 rtl/haar_lift_stage.sv | 90 +++++++++
 tb/tb_haar_lift_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/haar_lift_stage.sv
// Integer Haar lifting stage: pairs even/odd samples into (s, d) coefficients; an odd tail is padded with o=e.
// Latency: 1 cycle from accepting the odd (or padded last) sample to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a pending pair holds stable until taken.
module haar_lift_stage #(
    parameter int size  = 32,
    parameter int IDX_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [size-1:0]        in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [size-1:0]        out_s,
    output logic [size:0]          out_d,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last
);

    typedef enum logic {EVEN, ODD} state_t;

    state_t                 state;
    logic [size-1:0]        e_q;
    logic [IDX_W-1:0]       cnt;

    logic                   in_xfer;
    logic                   out_xfer;
    logic                   load;
    logic signed [size:0]   e_x;
    logic signed [size:0]   o_x;
    logic signed [size:0]   d_c;
    logic signed [size:0]   s_c;

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign load     = in_xfer && ((state == ODD) || in_last);

    // One guard bit keeps o - e exact; s = e + floor(d/2) always fits back in size bits.
    always_comb begin
        e_x = {e_q[size-1], e_q};
        o_x = {in_data[size-1], in_data};
        d_c = o_x - e_x;
        s_c = e_x + (d_c >>> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EVEN;
            e_q       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_s     <= '0;
            out_d     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (in_xfer) begin
                if (state == EVEN) begin
                    if (!in_last) begin
                        e_q   <= in_data;
                        state <= ODD;
                    end
                end else begin
                    state <= EVEN;
                end
            end

            if (load) begin
                out_valid <= 1'b1;
                out_idx   <= cnt;
                out_last  <= in_last;
                if (state == ODD) begin
                    out_s <= s_c[size-1:0];
                    out_d <= d_c;
                end else begin
                    // Odd-length tail: o=e gives d=0, s=e.
                    out_s <= in_data;
                    out_d <= '0;
                end
                cnt <= in_last ? '0 : cnt + {{(IDX_W-1){1'b0}}, 1'b1};
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_haar_lift_stage.sv
// Directed bench for haar_lift_stage: table of pairs plus stall, streaming and mid-frame reset sequences.
module tb_haar_lift_stage;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_s;
    logic signed [32:0] out_d;
    logic [15:0]        out_idx;
    logic               out_last;

    int total  = 0;
    int passed = 0;

    haar_lift_stage #(.size(32), .IDX_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_d(out_d),
        .out_idx(out_idx), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     e;
        int     o;
        bit     pad;
        bit     last;
        int     exp_s;
        longint exp_d;
        int     exp_idx;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_pair(input string tag, input int s, input longint d, input int idx, input bit last);
        check({tag, " valid"}, longint'(out_valid), 1);
        check({tag, " s"}, longint'(out_s), longint'(s));
        check({tag, " d"}, longint'(out_d), d);
        check({tag, " idx"}, longint'(out_idx), longint'(idx));
        check({tag, " last"}, longint'(out_last), longint'(last));
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int v, input bit l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = v;
        in_last  = l;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            total++;
            $display("FAIL send timeout: in_ready stuck at 0, expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int got_s [$];
        longint got_d [$];
        int got_idx [$];
        int got_last [$];
        int got_cyc [$];
        int stream [8];

        vecs[0] = '{10, 14, 0, 1, 12, 4, 0};
        vecs[1] = '{-3, 4, 0, 0, 0, 7, 0};
        vecs[2] = '{7, -8, 0, 1, -1, -15, 1};
        vecs[3] = '{32'h7FFFFFFF, 32'sh80000000, 0, 1, -1, -64'sd4294967295, 0};
        vecs[4] = '{1, 2, 0, 0, 1, 1, 0};
        vecs[5] = '{5, 0, 1, 1, 5, 0, 1};
        vecs[6] = '{100, -101, 0, 1, -1, -201, 0};
        vecs[7] = '{-5, -5, 0, 1, -5, 0, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_s", longint'(out_s), 0);
        check("reset out_d", longint'(out_d), 0);
        check("reset out_idx", longint'(out_idx), 0);
        check("reset out_last", longint'(out_last), 0);
        check("reset in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].pad) begin
                send(vecs[i].e, 1'b1);
            end else begin
                send(vecs[i].e, 1'b0);
                send(vecs[i].o, vecs[i].last);
            end
            check_pair($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_d, vecs[i].exp_idx, vecs[i].last);
        end
        @(negedge clk);
        check("drain out_valid", longint'(out_valid), 0);

        // Stall: pending pair must hold while a would-be sample sits on the input.
        out_ready = 1'b0;
        send(20, 1'b0);
        send(30, 1'b1);
        in_valid = 1'b1;
        in_data  = 99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d in_ready", i), longint'(in_ready), 0);
            check_pair($sformatf("stall%0d", i), 25, 10, 0, 1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", longint'(out_valid), 0);

        // Continuous stream of 8 samples with out_ready high.
        stream = '{1, 3, -2, 6, 100, 50, -7, -7};
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (out_valid) begin
                got_s.push_back(out_s);
                got_d.push_back(out_d);
                got_idx.push_back(int'(out_idx));
                got_last.push_back(int'(out_last));
                got_cyc.push_back(cyc);
            end
            if (cyc < 8) begin
                check($sformatf("stream%0d in_ready", cyc), longint'(in_ready), 1);
                in_valid = 1'b1;
                in_data  = stream[cyc];
                in_last  = (cyc == 7);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
        end
        check("stream pair count", longint'(got_s.size()), 4);
        if (got_s.size() == 4) begin
            check("stream p0 s", got_s[0], 2);
            check("stream p0 d", got_d[0], 2);
            check("stream p1 s", got_s[1], 2);
            check("stream p1 d", got_d[1], 8);
            check("stream p2 s", got_s[2], 75);
            check("stream p2 d", got_d[2], -50);
            check("stream p3 s", got_s[3], -7);
            check("stream p3 d", got_d[3], 0);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("stream p%0d idx", k), got_idx[k], k);
                check($sformatf("stream p%0d last", k), got_last[k], (k == 3) ? 1 : 0);
                check($sformatf("stream p%0d cycle", k), got_cyc[k], 2 * k + 2);
            end
        end

        // Mid-frame reset discards the held even sample.
        send(9, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset out_valid", longint'(out_valid), 0);
        send(2, 1'b0);
        check("midreset no early pair", longint'(out_valid), 0);
        send(6, 1'b1);
        check_pair("midreset pair", 4, 4, 0, 1'b1);
        @(negedge clk);
        check("midreset single pair", longint'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
